// File: rtl/twiddle_mult_pipe_pkg.sv
// Shared defaults, rounding-mode encoding and {re, im} pack/unpack helpers
// for the pipelined twiddle-factor multiplier.
`ifndef TWIDDLE_MULT_PIPE_PKG_SV
`define TWIDDLE_MULT_PIPE_PKG_SV

// Complex words are packed as {re, im}, real part in the upper half.
`define TMP_PACK(re, im) {re, im}
`define TMP_RE(v, w) v[2*(w)-1 -: (w)]
`define TMP_IM(v, w) v[(w)-1 -: (w)]

package twiddle_mult_pipe_pkg;

    localparam int unsigned W_DEF     = 12;
    localparam int unsigned FRAC_DEF  = 10;
    localparam int unsigned TW_DEF    = 12;
    localparam int unsigned TFRAC_DEF = 10;

    typedef enum int unsigned {
        RND_TRUNC   = 0,
        RND_HALF_UP = 1
    } round_mode_e;

endpackage

`endif

// File: rtl/twiddle_mult_pipe_sat_round.sv
// Optional round-half-up, arithmetic right shift and saturation of one
// wide sum down to the output word, with an overflow indication.
module sat_round
    import twiddle_mult_pipe_pkg::*;
#(
    parameter int unsigned IN_W  = 26,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned SHIFT = 10,
    parameter int unsigned ROUND = RND_TRUNC
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    ovf_o
);

    // One guard bit so the rounding bias can never wrap the sum.
    localparam logic signed [IN_W:0] BIAS =
        (ROUND == int'(RND_HALF_UP) && SHIFT > 0)
            ? ((IN_W+1)'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0))
            : (IN_W+1)'(0);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;

    // Bias, shift and clamp into the signed output range.
    always_comb begin
        biased  = (IN_W+1)'(din_i) + BIAS;
        shifted = biased >>> SHIFT;
        dout_o  = shifted[OUT_W-1:0];
        ovf_o   = 1'b0;
        if (shifted > MAXV) begin
            dout_o = MAXV[OUT_W-1:0];
            ovf_o  = 1'b1;
        end else if (shifted < MINV) begin
            dout_o = MINV[OUT_W-1:0];
            ovf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// Three-stage pipelined complex multiply C x T (or C x conj(T)) with
// global-stall flow control, rounding, saturation and sticky overflow.
module twiddle_mult_pipe
    import twiddle_mult_pipe_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned TFRAC = TFRAC_DEF,
    parameter int unsigned ROUND = RND_TRUNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    C,
    input  logic [2*TW-1:0]   T,
    input  logic              conj,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned PW        = W + TW + 1;
    localparam int unsigned SW        = W + TW + 2;
    // Product carries FRAC + TFRAC fraction bits; drop back to FRAC.
    localparam int unsigned PROD_FRAC = FRAC + TFRAC;
    localparam int unsigned SHIFT     = PROD_FRAC - FRAC;

    logic en;

    logic signed [W-1:0]  c_r_d, c_i_d;
    logic signed [TW-1:0] t_r_d;
    logic signed [TW:0]   t_i_d;

    logic                 s1_v_q;
    logic signed [W-1:0]  s1_cr_q, s1_ci_q;
    logic signed [TW-1:0] s1_tr_q;
    logic signed [TW:0]   s1_ti_q;

    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic                 s2_v_q;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    logic signed [SW-1:0] re_sum, im_sum;
    logic signed [W-1:0]  o_r_d, o_i_d;
    logic                 ovf_r_d, ovf_i_d;

    logic                 out_valid_q;
    logic [2*W-1:0]       out_q;
    logic                 ovf_q;

    assign en        = ~(out_valid_q & ~out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

    // Unpack inputs; conjugation negates T_i with one extra bit so -2^(TW-1) is exact.
    always_comb begin
        c_r_d = $signed(`TMP_RE(C, W));
        c_i_d = $signed(`TMP_IM(C, W));
        t_r_d = $signed(`TMP_RE(T, TW));
        t_i_d = (TW+1)'($signed(`TMP_IM(T, TW)));
        if (conj) begin
            t_i_d = -t_i_d;
        end
    end

    // Stage 1: capture the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_cr_q <= '0;
            s1_ci_q <= '0;
            s1_tr_q <= '0;
            s1_ti_q <= '0;
        end else if (en) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_cr_q <= c_r_d;
                s1_ci_q <= c_i_d;
                s1_tr_q <= t_r_d;
                s1_ti_q <= t_i_d;
            end
        end
    end

    // Four full-precision partial products.
    always_comb begin
        p_rr_d = PW'(s1_cr_q) * PW'(s1_tr_q);
        p_ii_d = PW'(s1_ci_q) * PW'(s1_ti_q);
        p_ri_d = PW'(s1_cr_q) * PW'(s1_ti_q);
        p_ir_d = PW'(s1_ci_q) * PW'(s1_tr_q);
    end

    // Stage 2: register the products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q <= 1'b0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                p_rr_q <= p_rr_d;
                p_ii_q <= p_ii_d;
                p_ri_q <= p_ri_d;
                p_ir_q <= p_ir_d;
            end
        end
    end

    assign re_sum = SW'(p_rr_q) - SW'(p_ii_q);
    assign im_sum = SW'(p_ri_q) + SW'(p_ir_q);

    sat_round #(.IN_W(SW), .OUT_W(W), .SHIFT(SHIFT), .ROUND(ROUND)) u_sat_re (
        .din_i  (re_sum),
        .dout_o (o_r_d),
        .ovf_o  (ovf_r_d)
    );

    sat_round #(.IN_W(SW), .OUT_W(W), .SHIFT(SHIFT), .ROUND(ROUND)) u_sat_im (
        .din_i  (im_sum),
        .dout_o (o_i_d),
        .ovf_o  (ovf_i_d)
    );

    // Stage 3: output register; out only changes when a valid result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (en) begin
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_q <= `TMP_PACK(o_r_d, o_i_d);
            end
        end
    end

    // Sticky overflow; a new saturation takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (en & s2_v_q & (ovf_r_d | ovf_i_d)) | (ovf_q & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Directed bench for twiddle_mult_pipe: a truncating and a rounding instance
// share one stimulus stream.
module tb_twiddle_mult_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [23:0] C;
    logic [23:0] T;
    logic        conj;
    logic        out_ready;
    logic        ovf_clr;

    logic        in_ready0, out_valid0, ovf0;
    logic [23:0] out0;
    logic        in_ready1, out_valid1, ovf1;
    logic [23:0] out1;

    int n_checks = 0;
    int n_errors = 0;

    twiddle_mult_pipe #(.W(12), .FRAC(10), .TW(12), .TFRAC(10), .ROUND(0)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .C(C), .T(T), .conj(conj), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    twiddle_mult_pipe #(.W(12), .FRAC(10), .TW(12), .TFRAC(10), .ROUND(1)) u_dut_round (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .C(C), .T(T), .conj(conj), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int re_of(input logic [23:0] v);
        logic [11:0] h;
        h = v[23:12];
        return int'($signed(h));
    endfunction

    function automatic int im_of(input logic [23:0] v);
        logic [11:0] l;
        l = v[11:0];
        return int'($signed(l));
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input int cr, input int ci, input int tr, input int ti, input logic cj);
        C        = {12'(cr), 12'(ci)};
        T        = {12'(tr), 12'(ti)};
        conj     = cj;
        in_valid = 1'b1;
    endtask

    // One isolated beat: checks latency and both instances' results.
    task automatic run_beat(input string tag, input int cr, input int ci, input int tr, input int ti,
                            input logic cj, input int er0, input int ei0, input int er1, input int ei1,
                            input int eovf);
        int lat;
        @(negedge clk);
        drive_beat(cr, ci, tr, ti, cj);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid0 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 3);
        check_eq({tag, "_vld_rnd"}, int'(out_valid1), 1);
        check_eq({tag, "_re_trunc"}, re_of(out0), er0);
        check_eq({tag, "_im_trunc"}, im_of(out0), ei0);
        check_eq({tag, "_re_rnd"}, re_of(out1), er1);
        check_eq({tag, "_im_rnd"}, im_of(out1), ei1);
        check_eq({tag, "_ovf"}, int'(ovf0), eovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        int   got_r[$];
        int   got_i[$];
        bit   ready_bad;
        bit   stall_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        C         = '0;
        T         = '0;
        conj      = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid0), 0);
        check_eq("rst_out", int'(out0), 0);
        check_eq("rst_ovf", int'(ovf0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", int'(in_ready0), 1);

        // 1: identity twiddle
        run_beat("t1_ident", 512, 256, 1024, 0, 1'b0, 512, 256, 512, 256, 0);
        // 2: multiply by j and by conj(j)
        run_beat("t2_j", 512, 256, 0, 1024, 1'b0, -256, 512, -256, 512, 0);
        run_beat("t2_conj", 512, 256, 0, 1024, 1'b1, 256, -512, 256, -512, 0);
        // 3: truncate vs round-half-up on half-LSB results
        run_beat("t3_neg_half", -1, 0, 512, 0, 1'b0, -1, 0, 0, 0, 0);
        run_beat("t3_pos_half", 1, 0, 512, 0, 1'b0, 0, 0, 1, 0, 0);
        // 4: saturation, sticky overflow, clear, set-beats-clear
        run_beat("t4_sat", 2047, -2048, 1024, 1024, 1'b0, 2047, -1, 2047, -1, 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check_eq("t4_ovf_cleared", int'(ovf0), 0);
        check_eq("t4_ovf_cleared_rnd", int'(ovf1), 0);
        @(negedge clk);
        drive_beat(2047, -2048, 1024, 1024, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check_eq("t4_setclr_vld", int'(out_valid0), 1);
        check_eq("t4_setclr_ovf", int'(ovf0), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // 5: 8 back-to-back beats, out_ready low in cycles 4..7; T = j so out = (-C_i, C_r)
        k          = 0;
        ready_bad  = 1'b0;
        stall_seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (out_valid0 && out_ready) begin
                got_r.push_back(re_of(out0));
                got_i.push_back(im_of(out0));
            end
            if (k < 8) drive_beat(10 + k, -(20 + k), 0, 1024, 1'b0);
            else       in_valid = 1'b0;
            #1;
            if (in_ready0 != !(out_valid0 && !out_ready)) ready_bad = 1'b1;
            if (!in_ready0) stall_seen = 1'b1;
            if (in_valid && in_ready0) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("t5_accepted", k, 8);
        check_eq("t5_count", got_r.size(), 8);
        check_eq("t5_ready_rule", int'(ready_bad), 0);
        check_eq("t5_stall_seen", int'(stall_seen), 1);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5_re%0d", i), (i < got_r.size()) ? got_r[i] : -9999, 20 + i);
            check_eq($sformatf("t5_im%0d", i), (i < got_i.size()) ? got_i[i] : -9999, 10 + i);
        end

        // 6: asynchronous reset with three saturating beats in flight
        @(negedge clk);
        drive_beat(2047, -2048, 1024, 1024, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("t6_pre_vld", int'(out_valid0), 1);
        check_eq("t6_pre_ovf", int'(ovf0), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_vld", int'(out_valid0), 0);
        check_eq("t6_rst_out", int'(out0), 0);
        check_eq("t6_rst_ovf", int'(ovf0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t6_in_ready", int'(in_ready0), 1);
        run_beat("t6_after", 512, 256, 0, 1024, 1'b0, -256, 512, -256, 512, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
